// File: rtl/vga_if.sv
// -----------------------------------------------------------------------------
// vga_if -- timing bundle produced by vga_sync
//
// Carries the seven outputs of the VGA timing generator as one group:
//   hsync      horizontal sync, active-low
//   vsync      vertical sync, active-low
//   video_on   high while the current pixel is in the visible area
//   pixel_x    current column (10 bit)
//   pixel_y    current line   (10 bit)
//   line_tick  one-cycle pulse on the last pixel of each line
//   frame_tick one-cycle pulse on the last pixel of each frame
//
// Modports:
//   master  the timing generator (drives everything)
//   slave   any consumer (pixel pipeline, game logic)
// -----------------------------------------------------------------------------
interface vga_if;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       line_tick;
    logic       frame_tick;

    modport master (
        output hsync, vsync, video_on, pixel_x, pixel_y, line_tick, frame_tick
    );

    modport slave (
        input  hsync, vsync, video_on, pixel_x, pixel_y, line_tick, frame_tick
    );
endinterface

// File: rtl/vga_sync.sv
// -----------------------------------------------------------------------------
// vga_sync -- 640x480@60 VGA timing generator
//
// A free-running column counter (h_cnt) and line counter (v_cnt) are decoded
// into sync pulses, the visible-area flag, the pixel coordinates and the
// line/frame ticks.
//
// Ports:
//   clk    in   pixel clock (25 MHz, divide-by-4 of the system clock)
//   clr_n  in   asynchronous active-low reset, shared with the clock divider
//   vga    out  vga_if.master: hsync, vsync, video_on, pixel_x, pixel_y,
//               line_tick, frame_tick
//
// Build option:
//   VGA_SYNC_OUTREG_EN  when defined, all seven outputs are registered
//                       (one clk of latency, still mutually aligned); when
//                       undefined they are zero-latency decodes of the
//                       counters, forced to their idle values while clr_n
//                       is low.
// -----------------------------------------------------------------------------
module vga_sync #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic clk,
    input  logic clr_n,
    vga_if.master vga
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_BEGIN = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic       line_tick;
        logic       frame_tick;
        logic [9:0] pixel_x;
        logic [9:0] pixel_y;
    } vga_out_t;

    // Idle values seen by consumers while the block is held in reset.
    localparam vga_out_t OUT_IDLE = '{
        hsync:      1'b1,
        vsync:      1'b1,
        video_on:   1'b0,
        line_tick:  1'b0,
        frame_tick: 1'b0,
        pixel_x:    10'd0,
        pixel_y:    10'd0
    };

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_last;
    logic       v_last;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // ------------------------------------------------------------------
    // Counters. Both wrap on the same edge at the end of a frame, so the
    // cycle after (H_LAST, V_LAST) is always (0, 0).
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values; v_cnt depends on the old h_cnt here.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else begin
            h_cnt <= h_last ? 10'd0 : h_cnt + 10'd1;
            if (h_last) begin
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode of the current counter position.
    // ------------------------------------------------------------------
    vga_out_t dec;

    // NOTE: dec gets a full default before any field is written, so no
    // path through this block can leave a bit unassigned (no latches).
    always_comb begin
        dec            = OUT_IDLE;
        dec.hsync      = !((h_cnt >= HS_BEGIN) && (h_cnt < HS_END));
        dec.vsync      = !((v_cnt >= VS_BEGIN) && (v_cnt < VS_END));
        dec.video_on   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        dec.line_tick  = h_last;
        dec.frame_tick = h_last && v_last;
        dec.pixel_x    = h_cnt;
        dec.pixel_y    = v_cnt;
    end

    // ------------------------------------------------------------------
    // Output stage.
    // ------------------------------------------------------------------
    vga_out_t out;

`ifdef VGA_SYNC_OUTREG_EN
    // Registered outputs: one clk behind the counters, all fields together.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            out <= OUT_IDLE;
        end else begin
            out <= dec;
        end
    end
`else
    // NOTE: the counters alone are not enough in reset -- position (0,0)
    // decodes as visible -- so the outputs are forced idle while clr_n is low.
    assign out = clr_n ? dec : OUT_IDLE;
`endif

    assign vga.hsync      = out.hsync;
    assign vga.vsync      = out.vsync;
    assign vga.video_on   = out.video_on;
    assign vga.line_tick  = out.line_tick;
    assign vga.frame_tick = out.frame_tick;
    assign vga.pixel_x    = out.pixel_x;
    assign vga.pixel_y    = out.pixel_y;

endmodule

// File: tb/tb_vga_sync.sv
// -----------------------------------------------------------------------------
// tb_vga_sync -- directed bench for vga_sync
//
// Two instances share clk and clr_n:
//   dut_d  default 640x480 timing (line-level behaviour, 800-clk lines)
//   dut_s  shrunken timing 8/2/3/2 x 6/2/2/3 (15 x 13 = 195 clks/frame) so
//          whole-frame behaviour (vsync width, frame_tick, wraps, visible
//          count) is exercised in a few hundred clocks.
// Expected values are hand-computed from the timing numbers; LAT accounts
// for the optional output register.
// -----------------------------------------------------------------------------
module tb_vga_sync;

`ifdef VGA_SYNC_OUTREG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    // Shrunken timing for dut_s.
    localparam int S_HTOT  = 15;
    localparam int S_VTOT  = 13;
    localparam int S_FRAME = S_HTOT * S_VTOT;   // 195

    logic clk;
    logic clr_n;

    vga_if vga_d ();
    vga_if vga_s ();

    vga_sync dut_d (
        .clk   (clk),
        .clr_n (clr_n),
        .vga   (vga_d)
    );

    vga_sync #(
        .H_DISPLAY (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (2),
        .V_DISPLAY (6),
        .V_FRONT   (2),
        .V_SYNC    (2),
        .V_BACK    (3)
    ) dut_s (
        .clk   (clk),
        .clr_n (clr_n),
        .vga   (vga_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string who, input int hs, input int vs,
                              input int vo, input int lt, input int ft,
                              input int px, input int py);
        check({who, " hsync"},      hs, 1);
        check({who, " vsync"},      vs, 1);
        check({who, " video_on"},   vo, 0);
        check({who, " line_tick"},  lt, 0);
        check({who, " frame_tick"}, ft, 0);
        check({who, " pixel_x"},    px, 0);
        check({who, " pixel_y"},    py, 0);
    endtask

    // Line-level statistics (dut_d, first line e = 0..799).
    int hs_low_d    = 0;
    int hs_first_px = -1;
    int hs_first_e  = -1;
    int lt_cnt_d    = 0;
    int lt_px_d     = -1;
    int vo_639      = -1;
    int vo_640      = -1;
    int px_800      = -1;
    int py_800      = -1;
    int ft_d        = 0;
    int vs_low_d    = 0;
    int bad_d       = 0;

    // Frame-level statistics (dut_s, first frame e = 0..194).
    int vs_low_s  = 0;
    int hs_low_s  = 0;
    int vo_cnt_s  = 0;
    int ft_cnt_s  = 0;
    int ft_px_s   = -1;
    int ft_py_s   = -1;
    int px_195    = -1;
    int py_195    = -1;
    int vo_s_8_0  = -1;
    int vo_s_0_6  = -1;
    int bad_s     = 0;

    initial begin
        clr_n = 1'b0;
        repeat (3) @(negedge clk);

        // Held in reset: idle outputs on both instances.
        check_idle("rst_d", vga_d.hsync, vga_d.vsync, vga_d.video_on,
                   vga_d.line_tick, vga_d.frame_tick,
                   vga_d.pixel_x, vga_d.pixel_y);
        check_idle("rst_s", vga_s.hsync, vga_s.vsync, vga_s.video_on,
                   vga_s.line_tick, vga_s.frame_tick,
                   vga_s.pixel_x, vga_s.pixel_y);

        // Release away from the rising edge; k counts rising edges since.
        clr_n = 1'b1;
        #1;
        for (int k = 0; k <= 1700 + LAT; k++) begin
            int e;
            int es;
            if (k > 0) @(negedge clk);
            e = k - LAT;            // position the outputs should show
            if (e >= 0) begin
                // ---- default instance ----
                if (int'(vga_d.pixel_x) != e % 800 ||
                    int'(vga_d.pixel_y) != e / 800) bad_d++;
                if (e < 800) begin
                    if (!vga_d.hsync) begin
                        hs_low_d++;
                        if (hs_first_px < 0) begin
                            hs_first_px = int'(vga_d.pixel_x);
                            hs_first_e  = e;
                        end
                    end
                    if (vga_d.line_tick) begin
                        lt_cnt_d++;
                        lt_px_d = int'(vga_d.pixel_x);
                    end
                end
                if (e == 639) vo_639 = int'(vga_d.video_on);
                if (e == 640) vo_640 = int'(vga_d.video_on);
                if (e == 800) begin
                    px_800 = int'(vga_d.pixel_x);
                    py_800 = int'(vga_d.pixel_y);
                end
                if (vga_d.frame_tick) ft_d++;
                if (!vga_d.vsync) vs_low_d++;

                // ---- shrunken instance ----
                es = e % S_FRAME;
                if (int'(vga_s.pixel_x) != es % S_HTOT ||
                    int'(vga_s.pixel_y) != es / S_HTOT) bad_s++;
                if (e < S_FRAME) begin
                    if (!vga_s.vsync) vs_low_s++;
                    if (!vga_s.hsync && e < S_HTOT) hs_low_s++;
                    if (vga_s.video_on) vo_cnt_s++;
                    if (vga_s.frame_tick) begin
                        ft_cnt_s++;
                        ft_px_s = int'(vga_s.pixel_x);
                        ft_py_s = int'(vga_s.pixel_y);
                    end
                end
                if (e == 8)       vo_s_8_0 = int'(vga_s.video_on);
                if (e == 90)      vo_s_0_6 = int'(vga_s.video_on);
                if (e == S_FRAME) begin
                    px_195 = int'(vga_s.pixel_x);
                    py_195 = int'(vga_s.pixel_y);
                end
            end
        end

        // Line-level results.
        check("d hsync low width",      hs_low_d, 96);
        check("d hsync fall pixel_x",   hs_first_px, 656);
        check("d hsync fall position",  hs_first_e, 656);
        check("d line_tick count",      lt_cnt_d, 1);
        check("d line_tick pixel_x",    lt_px_d, 799);
        check("d video_on at 639,0",    vo_639, 1);
        check("d video_on at 640,0",    vo_640, 0);
        check("d pixel_x after line",   px_800, 0);
        check("d pixel_y after line",   py_800, 1);
        check("d vsync low lines 0-2",  vs_low_d, 0);
        check("d frame_tick lines 0-2", ft_d, 0);
        check("d position tracking",    bad_d, 0);

        // Frame-level results.
        check("s vsync low width",      vs_low_s, 30);
        check("s hsync low width",      hs_low_s, 3);
        check("s video_on count",       vo_cnt_s, 48);
        check("s frame_tick count",     ft_cnt_s, 1);
        check("s frame_tick pixel_x",   ft_px_s, 14);
        check("s frame_tick pixel_y",   ft_py_s, 12);
        check("s pixel_x after frame",  px_195, 0);
        check("s pixel_y after frame",  py_195, 0);
        check("s video_on at 8,0",      vo_s_8_0, 0);
        check("s video_on at 0,6",      vo_s_0_6, 0);
        check("s position tracking",    bad_s, 0);

        // Position 1700: dut_d at (100,2), dut_s at (5,9) inside vsync.
        check("pre-rst d pixel_x",  vga_d.pixel_x, 100);
        check("pre-rst d video_on", vga_d.video_on, 1);
        check("pre-rst s pixel_y",  vga_s.pixel_y, 9);
        check("pre-rst s vsync",    vga_s.vsync, 0);

        // Mid-frame reset: effect must be immediate, not on the next edge.
        #1 clr_n = 1'b0;
        #1;
        check_idle("async_d", vga_d.hsync, vga_d.vsync, vga_d.video_on,
                   vga_d.line_tick, vga_d.frame_tick,
                   vga_d.pixel_x, vga_d.pixel_y);
        check_idle("async_s", vga_s.hsync, vga_s.vsync, vga_s.video_on,
                   vga_s.line_tick, vga_s.frame_tick,
                   vga_s.pixel_x, vga_s.pixel_y);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold d pixel_x", vga_d.pixel_x, 0);
        check("hold s pixel_y", vga_s.pixel_y, 0);
        check("hold s vsync",   vga_s.vsync, 1);

        // Release: first edge brings the counters to (1,0).
        clr_n = 1'b1;
        @(negedge clk);
        check("resume1 d pixel_x", vga_d.pixel_x, 1 - LAT);
        check("resume1 d pixel_y", vga_d.pixel_y, 0);
        check("resume1 s pixel_x", vga_s.pixel_x, 1 - LAT);
        check("resume1 s pixel_y", vga_s.pixel_y, 0);
        check("resume1 d video_on", vga_d.video_on, 1);
        @(negedge clk);
        check("resume2 d pixel_x", vga_d.pixel_x, 2 - LAT);
        check("resume2 s pixel_x", vga_s.pixel_x, 2 - LAT);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Watchdog: the stimulus above needs roughly 1800 clks.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

endmodule
